mem_node: RTL and testbench

Synchronous, parametrised packet-attached memory node for the NoC. It accepts read, write and burst-read request packets on a valid/ready input port and stores neuron/filter data addressed by (timestep, y, x). It returns response packets addressed to the requesting node on a valid/ready output port. It generalises the CSP memory block plus wrapper into one clocked block with configurable geometry, burst reads and error reporting.

---
 rtl/mem_node_pkg.sv | 69 ++++++
 rtl/mem_node_if.sv | 33 +++
 rtl/mem_node_ram.sv | 39 +++
 rtl/mem_node.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_node.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_node_pkg.sv
// -----------------------------------------------------------------------------
// mem_node_pkg
// Shared types and helpers for the packet-attached memory node.
//   opcode_e  : NoC packet opcodes (requests READ/WRITE/BURST, responses
//               RESP/ACK/ERR, 6 and 7 illegal)
//   state_e   : node FSM states
//   field_w() : bit width of a coordinate field ($clog2 of the extent, min 1)
//   pkt_t     : packet layout for the default geometry (dest, src, op, t, y,
//               x, data from MSB to LSB)
//   addr_of() : linear word address of (t, y, x)
// -----------------------------------------------------------------------------
package mem_node_pkg;

   typedef enum logic [2:0] {
      OP_READ  = 3'd0,
      OP_WRITE = 3'd1,
      OP_BURST = 3'd2,
      OP_RESP  = 3'd3,
      OP_ACK   = 3'd4,
      OP_ERR   = 3'd5,
      OP_ILL6  = 3'd6,
      OP_ILL7  = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_SEND   = 2'd2,
      ST_NEXT   = 2'd3
   } state_e;

   // A dimension of extent 1 still gets a 1-bit field so the layout never
   // contains zero-width slices.
   function automatic int field_w(input int extent);
      return (extent > 1) ? $clog2(extent) : 1;
   endfunction

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_X_DIM     = 5;
   localparam int DEF_Y_DIM     = 5;
   localparam int DEF_T_DIM     = 2;
   localparam int DEF_NODE_ID_W = 4;
   localparam int DEF_X_W       = field_w(DEF_X_DIM);
   localparam int DEF_Y_W       = field_w(DEF_Y_DIM);
   localparam int DEF_T_W       = field_w(DEF_T_DIM);
   localparam int DEF_PKT_W     = 2 * DEF_NODE_ID_W + 3 + DEF_T_W + DEF_Y_W
                                  + DEF_X_W + DEF_DATA_W;

   typedef struct packed {
      logic [DEF_NODE_ID_W-1:0] dest;
      logic [DEF_NODE_ID_W-1:0] src;
      opcode_e                  op;
      logic [DEF_T_W-1:0]       t;
      logic [DEF_Y_W-1:0]       y;
      logic [DEF_X_W-1:0]       x;
      logic [DEF_DATA_W-1:0]    data;
   } pkt_t;

   // Row-major (t, y, x) word address; the extents default to the standard
   // geometry and are overridden by parametrised users.
   function automatic int unsigned addr_of(input int unsigned t,
                                           input int unsigned y,
                                           input int unsigned x,
                                           input int unsigned y_dim = DEF_Y_DIM,
                                           input int unsigned x_dim = DEF_X_DIM);
      return (t * y_dim + y) * x_dim + x;
   endfunction

endpackage

// File: rtl/mem_node_if.sv
// -----------------------------------------------------------------------------
// mem_node_if
// Valid/ready request and response channels of the memory node.
//   pkt_in, pkt_in_valid    : request from the NoC      (master -> node)
//   pkt_in_ready            : node accepts a request     (node -> master)
//   pkt_out, pkt_out_valid  : response to the NoC       (node -> master)
//   pkt_out_ready           : NoC accepts the response   (master -> node)
// Modports: master (NoC / testbench side), slave (memory node side).
// -----------------------------------------------------------------------------
interface mem_node_if
   import mem_node_pkg::*;
#(
   parameter int PKT_W = DEF_PKT_W
) ();

   logic [PKT_W-1:0] pkt_in;
   logic             pkt_in_valid;
   logic             pkt_in_ready;
   logic [PKT_W-1:0] pkt_out;
   logic             pkt_out_valid;
   logic             pkt_out_ready;

   modport master (
      output pkt_in, pkt_in_valid, pkt_out_ready,
      input  pkt_in_ready, pkt_out, pkt_out_valid
   );

   modport slave (
      input  pkt_in, pkt_in_valid, pkt_out_ready,
      output pkt_in_ready, pkt_out, pkt_out_valid
   );

endinterface

// File: rtl/mem_node_ram.sv
// -----------------------------------------------------------------------------
// mem_node_ram
// Single-port synchronous RAM, DATA_W x DEPTH, with registered read.
//   clk   : clock
//   we    : write enable (wdata -> mem[addr] at the rising edge)
//   re    : read enable  (mem[addr] -> rdata at the rising edge, held otherwise)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
// Contents and read register are not reset so the array maps onto block RAM.
// -----------------------------------------------------------------------------
module mem_node_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 50,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_node.sv
// -----------------------------------------------------------------------------
// mem_node
// Packet-attached memory node: accepts READ / WRITE / BURST requests, stores
// words addressed by (t, y, x) and returns RESP / ACK / ERR packets to the
// requesting node.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any burst, drops both
//           pkt_in_ready and pkt_out_valid immediately
//   bus   : mem_node_if.slave (request in, response out, valid/ready)
// Optional feature macro: MEM_NODE_WRITE_ACK_EN -- when defined every accepted
// in-range WRITE is answered with an ACK carrying the written data; otherwise
// writes are silent (bad writes still get ERR).
// -----------------------------------------------------------------------------
module mem_node
   import mem_node_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int X_DIM     = 5,
   parameter int Y_DIM     = 5,
   parameter int T_DIM     = 2,
   parameter int NODE_ID_W = 4,
   parameter int MY_ID     = 0,
   parameter int BURST_MAX = 5
) (
   input  logic      clk,
   input  logic      rst_n,
   mem_node_if.slave bus
);

   localparam int X_W      = field_w(X_DIM);
   localparam int Y_W      = field_w(Y_DIM);
   localparam int T_W      = field_w(T_DIM);
   localparam int PKT_W    = 2 * NODE_ID_W + 3 + T_W + Y_W + X_W + DATA_W;
   localparam int DEPTH    = T_DIM * Y_DIM * X_DIM;
   localparam int AW       = field_w(DEPTH);
   localparam int CNT_W    = field_w(BURST_MAX + 1);

   // Field positions inside a packet, LSB first.
   localparam int X_LSB    = DATA_W;
   localparam int Y_LSB    = X_LSB + X_W;
   localparam int T_LSB    = Y_LSB + Y_W;
   localparam int OP_LSB   = T_LSB + T_W;
   localparam int SRC_LSB  = OP_LSB + 3;
   localparam int DEST_LSB = SRC_LSB + NODE_ID_W;

   state_e               state_q, state_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [NODE_ID_W-1:0] src_q, src_d;
   opcode_e              op_q, op_d;
   opcode_e              resp_op_q, resp_op_d;
   logic [T_W-1:0]       t_q, t_d;
   logic [Y_W-1:0]       y_q, y_d;
   logic [X_W-1:0]       x_q, x_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 from_ram_q, from_ram_d;
   logic [CNT_W-1:0]     remain_q, remain_d;

   logic                 ram_we;
   logic                 ram_re;
   logic [AW-1:0]        ram_addr;
   logic [DATA_W-1:0]    ram_rdata;

   int unsigned          base_addr;
   int unsigned          req_len;
   int unsigned          room;
   int unsigned          burst_words;
   logic                 in_range;
   logic                 op_is_req;
   logic [DATA_W-1:0]    out_data;
   logic [PKT_W-1:0]     pkt_out_w;
   logic                 unused_dest;

   // Routing already delivered the packet here; the dest field is not needed.
   assign unused_dest = ^bus.pkt_in[DEST_LSB +: NODE_ID_W];

   assign base_addr = addr_of(32'(t_q), 32'(y_q), 32'(x_q), Y_DIM, X_DIM);
   assign in_range  = (32'(t_q) < T_DIM) && (32'(y_q) < Y_DIM) && (32'(x_q) < X_DIM);
   assign op_is_req = (op_q == OP_READ) || (op_q == OP_WRITE) || (op_q == OP_BURST);

   // Number of words a burst really returns: requested length clamped to
   // 1..BURST_MAX, then cut so the last address stays below DEPTH.
   always_comb begin
      req_len = 32'(data_q);
      if (req_len == 0) begin
         req_len = 1;
      end else if (req_len > BURST_MAX) begin
         req_len = BURST_MAX;
      end
      room        = DEPTH - base_addr;
      burst_words = (req_len < room) ? req_len : room;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      src_d       = src_q;
      op_d        = op_q;
      resp_op_d   = resp_op_q;
      t_d         = t_q;
      y_d         = y_q;
      x_d         = x_q;
      data_d      = data_q;
      from_ram_d  = from_ram_q;
      remain_d    = remain_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      ram_addr    = AW'(base_addr);

      case (state_q)
         ST_IDLE: begin
            // Ready is registered so it stays low through reset and rises
            // one cycle after release.
            in_ready_d = 1'b1;
            if (in_ready_q && bus.pkt_in_valid) begin
               src_d      = bus.pkt_in[SRC_LSB +: NODE_ID_W];
               op_d       = opcode_e'(bus.pkt_in[OP_LSB +: 3]);
               t_d        = bus.pkt_in[T_LSB +: T_W];
               y_d        = bus.pkt_in[Y_LSB +: Y_W];
               x_d        = bus.pkt_in[X_LSB +: X_W];
               data_d     = bus.pkt_in[0 +: DATA_W];
               in_ready_d = 1'b0;
               state_d    = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if (!in_range || !op_is_req) begin
               resp_op_d   = OP_ERR;
               data_d      = '0;
               from_ram_d  = 1'b0;
               remain_d    = '0;
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
            end else if (op_q == OP_WRITE) begin
               ram_we = 1'b1;
`ifdef MEM_NODE_WRITE_ACK_EN
               // data_q still holds the written value, echoed in the ACK.
               resp_op_d   = OP_ACK;
               from_ram_d  = 1'b0;
               remain_d    = '0;
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
`else
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
`endif
            end else begin
               ram_re      = 1'b1;
               resp_op_d   = OP_RESP;
               from_ram_d  = 1'b1;
               remain_d    = (op_q == OP_BURST) ? CNT_W'(burst_words - 1) : '0;
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
            end
         end

         ST_SEND: begin
            if (bus.pkt_out_ready) begin
               out_valid_d = 1'b0;
               if (remain_q != '0) begin
                  state_d = ST_NEXT;
               end else begin
                  in_ready_d = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end

         ST_NEXT: begin
            // Step the echoed coordinates; the linear address simply
            // increments because the layout is row-major.
            if (32'(x_q) + 1 >= X_DIM) begin
               x_d = '0;
               if (32'(y_q) + 1 >= Y_DIM) begin
                  y_d = '0;
                  t_d = t_q + T_W'(1);
               end else begin
                  y_d = y_q + Y_W'(1);
               end
            end else begin
               x_d = x_q + X_W'(1);
            end
            ram_addr    = AW'(base_addr + 1);
            ram_re      = 1'b1;
            remain_d    = remain_q - CNT_W'(1);
            out_valid_d = 1'b1;
            state_d     = ST_SEND;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         src_q       <= '0;
         op_q        <= OP_READ;
         resp_op_q   <= OP_RESP;
         t_q         <= '0;
         y_q         <= '0;
         x_q         <= '0;
         data_q      <= '0;
         from_ram_q  <= 1'b0;
         remain_q    <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         src_q       <= src_d;
         op_q        <= op_d;
         resp_op_q   <= resp_op_d;
         t_q         <= t_d;
         y_q         <= y_d;
         x_q         <= x_d;
         data_q      <= data_d;
         from_ram_q  <= from_ram_d;
         remain_q    <= remain_d;
      end
   end

   mem_node_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (data_q),
      .rdata (ram_rdata)
   );

   // Read data comes straight from the RAM output register, which holds
   // while SEND waits, so the response appears the cycle after the access.
   assign out_data = from_ram_q ? ram_rdata : data_q;

   // The packet is forced to zero whenever it is not valid, which also gives
   // an all-zero output during reset.
   assign pkt_out_w = out_valid_q ?
                      {src_q, NODE_ID_W'(MY_ID), resp_op_q, t_q, y_q, x_q, out_data} :
                      '0;

   assign bus.pkt_out       = pkt_out_w;
   assign bus.pkt_out_valid = out_valid_q;
   assign bus.pkt_in_ready  = in_ready_q;

endmodule

// File: tb/tb_mem_node.sv
// -----------------------------------------------------------------------------
// tb_mem_node
// Self-checking bench for mem_node (default geometry 2 x 5 x 5, MY_ID = 9).
// A behavioural model (plain array + queue of expected packets) predicts every
// response; one compare process checks each accepted response, output
// stability under backpressure and pkt_in_ready while a response is pending.
// Directed sequences pin latency, burst walk, truncation, ERR and reset.
// Define MEM_NODE_WRITE_ACK_EN for both RTL and bench to cover ACK packets.
// -----------------------------------------------------------------------------
module tb_mem_node;
   import mem_node_pkg::*;

   localparam int PW    = DEF_PKT_W;
   localparam int DEPTH = 50;
   localparam int MY_ID = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_node_if #(.PKT_W(PW)) bus ();

   mem_node #(
      .DATA_W    (8),
      .X_DIM     (5),
      .Y_DIM     (5),
      .T_DIM     (2),
      .NODE_ID_W (4),
      .MY_ID     (MY_ID),
      .BURST_MAX (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int        checks  = 0;
   int        errors  = 0;
   int        bp_mode = 0;
   logic [7:0] mem_m [DEPTH];
   pkt_t      exp_q [$];
   pkt_t      got_q [$];
   pkt_t      prev_out;
   logic      prev_pend = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Behavioural model: what the node must answer for one request.
   task automatic model_req(input int op, input int t, input int y, input int x,
                            input int d, input int src);
      pkt_t e;
      int   a, n, b;
      e.dest = 4'(src);
      e.src  = 4'(MY_ID);
      e.t    = 1'(t);
      e.y    = 3'(y);
      e.x    = 3'(x);
      e.op   = OP_ERR;
      e.data = 8'd0;
      a = t * 25 + y * 5 + x;
      if (op > 2 || t > 1 || y > 4 || x > 4) begin
         exp_q.push_back(e);
      end else if (op == 1) begin
         mem_m[a] = 8'(d);
`ifdef MEM_NODE_WRITE_ACK_EN
         e.op   = OP_ACK;
         e.data = 8'(d);
         exp_q.push_back(e);
`endif
      end else begin
         n = (op == 0) ? 1 : ((d == 0) ? 1 : ((d > 5) ? 5 : d));
         e.op = OP_RESP;
         for (int i = 0; i < n; i++) begin
            b = a + i;
            if (b >= DEPTH) break;
            e.t    = 1'(b / 25);
            e.y    = 3'((b / 5) % 5);
            e.x    = 3'(b % 5);
            e.data = mem_m[b];
            exp_q.push_back(e);
         end
      end
   endtask

   // Compare process: every accepted response against the model queue.
   always @(negedge clk) begin
      pkt_t cur, e;
      if (!rst_n) begin
         prev_pend <= 1'b0;
      end else begin
         cur = bus.pkt_out;
         if (bus.pkt_out_valid) begin
            chk("in_ready_low_while_sending", 32'(bus.pkt_in_ready), 32'd0);
            if (prev_pend) chk("pkt_out_stable", 32'(cur), 32'(prev_out));
            if (bus.pkt_out_ready) begin
               $display("resp: dest=%0d src=%0d op=%0d t=%0d y=%0d x=%0d data=0x%02h",
                        cur.dest, cur.src, cur.op, cur.t, cur.y, cur.x, cur.data);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got 0x%07h required no response", cur);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_pkt", 32'(cur), 32'(e));
               end
               got_q.push_back(cur);
            end
         end
         prev_pend <= bus.pkt_out_valid & ~bus.pkt_out_ready;
         prev_out  <= cur;
      end
   end

   // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      bus.pkt_out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       bus.pkt_out_ready = 1'b1;
            1:       bus.pkt_out_ready = 1'($urandom_range(0, 1));
            default: bus.pkt_out_ready = 1'b0;
         endcase
      end
   end

   // Present a request and return #1 after its handshake edge (cycle 1).
   task automatic issue(input int op, input int t, input int y, input int x,
                        input int d, input int src);
      pkt_t p;
      int   n = 0;
      while (bus.pkt_in_ready !== 1'b1 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=%0b required 1", bus.pkt_in_ready);
      end
      p.dest = 4'(MY_ID);
      p.src  = 4'(src);
      p.op   = opcode_e'(3'(op));
      p.t    = 1'(t);
      p.y    = 3'(y);
      p.x    = 3'(x);
      p.data = 8'(d);
      bus.pkt_in       = p;
      bus.pkt_in_valid = 1'b1;
      $display("req: op=%0d src=%0d t=%0d y=%0d x=%0d data=0x%02h", op, src, t, y, x, d);
      model_req(op, t, y, x, d, src);
      @(posedge clk);
      #1;
      bus.pkt_in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || bus.pkt_in_ready !== 1'b1) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got %0d pending, in_ready=%0b required 0 pending and 1",
                  exp_q.size(), bus.pkt_in_ready);
      end
      exp_q.delete();
   endtask

   task automatic send(input int op, input int t, input int y, input int x,
                       input int d, input int src);
      issue(op, t, y, x, d, src);
      wait_idle();
   endtask

   initial begin
      int ey [4];
      int ex [4];
      int r, op, t, y, x, d;
      ey = '{0, 0, 1, 1};
      ex = '{3, 4, 0, 1};
      bus.pkt_in       = '0;
      bus.pkt_in_valid = 1'b0;

      // Reset
      #2 rst_n = 1'b0;
      #1;
      chk("reset_in_ready", 32'(bus.pkt_in_ready), 32'd0);
      chk("reset_out_valid", 32'(bus.pkt_out_valid), 32'd0);
      chk("reset_pkt_out", 32'(bus.pkt_out), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("in_ready_at_release", 32'(bus.pkt_in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("in_ready_after_release", 32'(bus.pkt_in_ready), 32'd1);

      // Fill memory so every read has a defined value
      for (int a = 0; a < DEPTH; a++) send(1, a / 25, (a / 5) % 5, a % 5, $urandom_range(0, 255), 1);

      // WRITE then READ at (1,2,3)
      got_q.delete();
      issue(1, 1, 2, 3, 'hA5, 2);
      chk("wr_cycle1_in_ready", 32'(bus.pkt_in_ready), 32'd0);
      @(posedge clk);
      #1;
`ifdef MEM_NODE_WRITE_ACK_EN
      chk("ack_cycle2_valid", 32'(bus.pkt_out_valid), 32'd1);
      wait_idle();
      chk("ack_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
         chk("ack_op", 32'(got_q[0].op), 32'd4);
         chk("ack_data", 32'(got_q[0].data), 32'hA5);
      end
`else
      chk("wr_cycle2_in_ready", 32'(bus.pkt_in_ready), 32'd1);
      wait_idle();
      chk("silent_write", 32'(got_q.size()), 32'd0);
`endif
      got_q.delete();
      issue(0, 1, 2, 3, 0, 2);
      chk("rd_cycle1_valid", 32'(bus.pkt_out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("rd_cycle2_valid", 32'(bus.pkt_out_valid), 32'd1);
      wait_idle();
      chk("rd_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0)
         chk("rd_resp_literal", 32'(got_q[0]),
             32'({4'd2, 4'd9, 3'd3, 1'd1, 3'd2, 3'd3, 8'hA5}));

      // BURST across a row boundary
      for (int i = 0; i < 4; i++) send(1, 0, (3 + i) / 5, (3 + i) % 5, 'h10 + i, 1);
      got_q.delete();
      send(2, 0, 0, 3, 4, 5);
      chk("burst_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_q.size()) begin
            chk("burst_y", 32'(got_q[i].y), 32'(ey[i]));
            chk("burst_x", 32'(got_q[i].x), 32'(ex[i]));
            chk("burst_data", 32'(got_q[i].data), 32'('h10 + i));
         end
      end

      // Backpressure for 5 cycles on a RESP
      bp_mode = 2;
      got_q.delete();
      issue(0, 0, 0, 3, 0, 7);
      @(posedge clk);
      #1;
      repeat (5) begin
         chk("bp_valid_held", 32'(bus.pkt_out_valid), 32'd1);
         chk("bp_in_ready_low", 32'(bus.pkt_in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      bp_mode = 0;
      wait_idle();
      chk("bp_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("bp_data", 32'(got_q[0].data), 32'h10);

      // Errors: x = X_DIM, op 7, bad write; memory untouched
      got_q.delete();
      send(0, 0, 0, 5, 0, 3);
      send(7, 0, 0, 3, 'hEE, 3);
      send(1, 0, 6, 3, 'h77, 3);
      send(0, 0, 0, 3, 0, 3);
      chk("err_count", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         chk("err_x_op", 32'(got_q[0].op), 32'd5);
         chk("err_x_data", 32'(got_q[0].data), 32'd0);
         chk("err_x_echo", 32'(got_q[0].x), 32'd5);
         chk("err_op7_op", 32'(got_q[1].op), 32'd5);
         chk("err_wr_op", 32'(got_q[2].op), 32'd5);
         chk("mem_unchanged", 32'(got_q[3].data), 32'h10);
      end

      // Burst of 3 from the last address is truncated to one word
      got_q.delete();
      send(2, 1, 4, 4, 3, 4);
      chk("trunc_count", 32'(got_q.size()), 32'd1);
      chk("trunc_idle", 32'(bus.pkt_in_ready), 32'd1);

      // Reset in the middle of a burst
      issue(2, 0, 2, 0, 5, 6);
      @(posedge clk);
      #1;
      chk("midburst_valid", 32'(bus.pkt_out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_valid_drop", 32'(bus.pkt_out_valid), 32'd0);
      chk("async_ready_drop", 32'(bus.pkt_in_ready), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_midreset", 32'(bus.pkt_in_ready), 32'd1);
      send(0, 0, 2, 0, 0, 6);

      // Random traffic
      for (int i = 0; i < 250; i++) begin
         bp_mode = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         t = $urandom_range(0, 1);
         y = $urandom_range(0, 4);
         x = $urandom_range(0, 4);
         d = $urandom_range(0, 255);
         if (r <= 2) op = 0;
         else if (r <= 5) op = 1;
         else if (r <= 7) begin op = 2; d = $urandom_range(0, 8); end
         else if (r == 8) op = $urandom_range(3, 7);
         else begin op = $urandom_range(0, 2); y = $urandom_range(0, 7); x = $urandom_range(0, 7); end
         send(op, t, y, x, d, $urandom_range(0, 15));
      end
      bp_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion required finish before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule
